// File: rtl/lsu_seq.sv
// Load/store sequencer: turns one decoded memory op into a req/ack bus transaction,
// generates byte enables and store-lane replication, aligns and sign-extends load data,
// and holds stall until the op completes or faults.
module lsu_seq #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  ld_cntr,
  input  logic [31:0] st_cntr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [29:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  // Selects which error flag pulses in StErr: 1 = timeout, 0 = misalign
  logic              to_q, to_d;

  logic [1:0]  op_size;
  logic        st_legal;
  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode the incoming op: size, store legality, alignment, enables and replicated data
  always_comb begin
    st_legal = 1'b1;
    op_size  = SzWord;
    if (mem_wr) begin
      // Store wins when both mem_rd and mem_wr are set
      unique case (st_cntr)
        32'h1111_1111: op_size = SzWord;
        32'h0000_1111: op_size = SzHalf;
        32'h0000_0011: op_size = SzByte;
        default: begin
          op_size  = SzWord;
          st_legal = 1'b0;
        end
      endcase
    end else begin
      unique case (ld_cntr)
        2'b01:   op_size = SzHalf;
        2'b10:   op_size = SzByte;
        default: op_size = SzWord;
      endcase
    end

    misalign = ((op_size == SzHalf) && addr[0]) ||
               ((op_size == SzWord) && (addr[1:0] != 2'b00));

    unique case (op_size)
      SzByte: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      SzHalf: begin
        be_calc    = 4'b0011 << addr[1:0];
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  // Align the returned word to the latched size and offset, sign-extending
  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (size_q)
      SzByte:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      SzHalf:  ld_data = {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  // Next-state logic and combinational stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && (mem_rd || mem_wr)) begin
          stall = 1'b1;
          if (mem_wr && !st_legal) begin
            state_d = StDone;
          end else if (misalign) begin
            state_d = StErr;
            to_d    = 1'b0;
          end else begin
            state_d = StReq;
            cnt_d   = '0;
            we_d    = mem_wr;
            addr_d  = addr[31:2];
            be_d    = be_calc;
            wdata_d = wdata_calc;
            size_d  = op_size;
            off_d   = addr[1:0];
          end
        end
      end
      StReq: begin
        stall = 1'b1;
        if (bus_ack) begin
          // An ack on the limit cycle still counts as success
          state_d = StDone;
          if (!we_q) rdata_d = ld_data;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StErr;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; async reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SzWord;
      off_q   <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end

  // Outputs decoded from state and latched bus fields
  always_comb begin
    bus_req      = (state_q == StReq);
    done         = (state_q == StDone);
    err_misalign = (state_q == StErr) && !to_q;
    err_timeout  = (state_q == StErr) && to_q;
    bus_we       = we_q;
    bus_addr     = {addr_q, 2'b00};
    bus_be       = be_q;
    bus_wdata    = wdata_q;
    rdata        = rdata_q;
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Scoreboard bench for lsu_seq: stimulus pushes expected results, a negedge monitor
// checks bus fields on request and results on done/err pulses.
module tb_lsu_seq;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mem_rd, mem_wr;
  logic [1:0]  ld_cntr;
  logic [31:0] st_cntr, addr, wdata;
  logic        stall, done, err_misalign, err_timeout;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  lsu_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ld_cntr(ld_cntr), .st_cntr(st_cntr), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .err_misalign(err_misalign),
    .err_timeout(err_timeout), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [2:0]  kind;  // {done, err_misalign, err_timeout}
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] rdata;
    int          start_cyc;
    int          done_cyc;
    int          req_cycles;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Bus responder: ack after ack_delay wait cycles of bus_req; -1 never acks
  int ack_delay = 0;
  int wcnt = 0;
  logic [31:0] rd_word = '0;
  always @(posedge clk) begin
    #1;
    if (bus_req && ack_delay >= 0 && wcnt == ack_delay) begin
      bus_ack   = 1'b1;
      bus_rdata = rd_word;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = 32'h5A5A_5A5A;
    end
    if (bus_req) wcnt++;
    else wcnt = 0;
  end

  // Monitor
  int   req_seen = 0;
  bit   bus_checked = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      req_seen    = 0;
      bus_checked = 1'b0;
    end else begin
      if (bus_req) begin
        chk("stall_in_req", stall, 1);
        if (sb.size() == 0) chk("req_without_op", bus_req, 0);
        else if (!bus_checked) begin
          chk("req_start_cycle", cyc, sb[0].start_cyc + 1);
          chk("bus_we", bus_we, sb[0].we);
          chk("bus_addr", bus_addr, sb[0].baddr);
          chk("bus_be", bus_be, sb[0].be);
          if (sb[0].we) chk("bus_wdata", bus_wdata, sb[0].bwd);
          bus_checked = 1'b1;
        end
        req_seen++;
      end
      if (done || err_misalign || err_timeout) begin
        if (sb.size() == 0) chk("pulse_without_op", {done, err_misalign, err_timeout}, 0);
        else begin
          e = sb.pop_front();
          chk("result_kind", {done, err_misalign, err_timeout}, e.kind);
          chk("rdata", rdata, e.rdata);
          chk("result_cycle", cyc, e.done_cyc);
          chk("req_cycles", req_seen, e.req_cycles);
          chk("stall_at_end", stall, 0);
        end
        req_seen    = 0;
        bus_checked = 1'b0;
      end
    end
  end

  task automatic op(input bit rd, input bit wr, input logic [1:0] ldc, input logic [31:0] stc,
                    input logic [31:0] a, input logic [31:0] wd, input int delay,
                    input logic [31:0] rword, input logic [2:0] kind, input bit has_bus,
                    input logic [31:0] baddr, input logic [3:0] be, input logic [31:0] bwd,
                    input logic [31:0] exp_rd);
    exp_t x;
    @(posedge clk); #1;
    start = 1'b1; mem_rd = rd; mem_wr = wr; ld_cntr = ldc; st_cntr = stc;
    addr = a; wdata = wd; ack_delay = delay; rd_word = rword;
    x.kind = kind; x.we = wr; x.baddr = baddr; x.be = be; x.bwd = bwd; x.rdata = exp_rd;
    x.start_cyc = cyc;
    if (!has_bus) begin
      x.req_cycles = 0;
      x.done_cyc   = cyc + 1;
    end else if (kind == 3'b001) begin
      x.req_cycles = int'(TIMEOUT);
      x.done_cyc   = cyc + 1 + int'(TIMEOUT);
    end else begin
      x.req_cycles = delay + 1;
      x.done_cyc   = cyc + 2 + delay;
    end
    sb.push_back(x);
    #1 chk("stall_on_start", stall, 1);
    @(posedge clk); #1;
    start = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      chk("op_completion", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    exp_t x;
    rst_n = 1'b0; start = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; ld_cntr = '0;
    st_cntr = '0; addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_errs", {err_misalign, err_timeout}, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_fields", {bus_we, bus_be, bus_addr | bus_wdata}, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_bus_req", bus_req, 0);
    chk("idle_stall", stall, 0);

    // rd wr ldc  st_cntr        addr          wdata         dly rword         kind has baddr be bwd exp_rd
    op(1, 0, 2'b00, 32'h0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 3'b100, 1, 32'h100, 4'b1111, 32'h0,
       32'hDEADBEEF);
    op(1, 0, 2'b10, 32'h0, 32'h103, 32'h0, 1, 32'h80FF0000, 3'b100, 1, 32'h100, 4'b1000, 32'h0,
       32'hFFFFFF80);
    op(1, 0, 2'b01, 32'h0, 32'h102, 32'h0, 0, 32'h80FF0000, 3'b100, 1, 32'h100, 4'b1100, 32'h0,
       32'hFFFF80FF);
    op(1, 0, 2'b10, 32'h0, 32'h101, 32'h0, 0, 32'h00007F00, 3'b100, 1, 32'h100, 4'b0010, 32'h0,
       32'h0000007F);
    op(1, 0, 2'b01, 32'h0, 32'h100, 32'h0, 0, 32'h12347FFF, 3'b100, 1, 32'h100, 4'b0011, 32'h0,
       32'h00007FFF);
    op(1, 0, 2'b11, 32'h0, 32'h108, 32'h0, 0, 32'h01234567, 3'b100, 1, 32'h108, 4'b1111, 32'h0,
       32'h01234567);
    // Stores: rdata holds the last load result
    op(0, 1, 2'b00, 32'h00000011, 32'h201, 32'h000000A5, 0, 32'h0, 3'b100, 1, 32'h200, 4'b0010,
       32'hA5A5A5A5, 32'h01234567);
    op(0, 1, 2'b00, 32'h00001111, 32'h202, 32'h1234ABCD, 2, 32'h0, 3'b100, 1, 32'h200, 4'b1100,
       32'hABCDABCD, 32'h01234567);
    // Both rd and wr: store wins, ld_cntr ignored
    op(1, 1, 2'b10, 32'h11111111, 32'h300, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 3'b100, 1, 32'h300,
       4'b1111, 32'hCAFEF00D, 32'h01234567);
    // Misaligned accesses: no bus cycle
    op(0, 1, 2'b00, 32'h11111111, 32'h302, 32'h0, 0, 32'h0, 3'b010, 0, 32'h0, 4'b0, 32'h0,
       32'h01234567);
    op(1, 0, 2'b01, 32'h0, 32'h101, 32'h0, 0, 32'h0, 3'b010, 0, 32'h0, 4'b0, 32'h0, 32'h01234567);
    // Illegal st_cntr: no-op store completes without a bus cycle
    op(0, 1, 2'b00, 32'h00000111, 32'h400, 32'h0, 0, 32'h0, 3'b100, 0, 32'h0, 4'b0, 32'h0,
       32'h01234567);
    // Ack withheld: timeout after TIMEOUT request cycles
    op(1, 0, 2'b00, 32'h0, 32'h500, 32'h0, -1, 32'h0, 3'b001, 1, 32'h500, 4'b1111, 32'h0,
       32'h01234567);
    // Ack on the final allowed cycle is success
    op(1, 0, 2'b00, 32'h0, 32'h600, 32'h0, int'(TIMEOUT) - 1, 32'h55AA55AA, 3'b100, 1, 32'h600,
       4'b1111, 32'h0, 32'h55AA55AA);

    // Reset during REQ
    @(posedge clk); #1;
    start = 1'b1; mem_rd = 1'b1; ld_cntr = 2'b00; addr = 32'h400; ack_delay = -1;
    x.kind = 3'b100; x.we = 1'b0; x.baddr = 32'h400; x.be = 4'b1111; x.bwd = 32'h0;
    x.rdata = 32'h0; x.start_cyc = cyc; x.done_cyc = 0; x.req_cycles = 0;
    sb.push_back(x);
    @(posedge clk); #1;
    start = 1'b0; mem_rd = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk("bus_req_before_reset", bus_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus_req", bus_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_pulses", {done, err_misalign, err_timeout}, 0);
    chk("rst_mid_rdata", rdata, 0);
    sb.delete();
    ack_delay = 0;
    @(posedge clk); #3 rst_n = 1'b1;

    op(1, 0, 2'b00, 32'h0, 32'h104, 32'h0, 0, 32'h0BADF00D, 3'b100, 1, 32'h104, 4'b1111, 32'h0,
       32'h0BADF00D);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
